div_seq: RTL and testbench

//  Multi-cycle signed/unsigned 32-bit divider sequencer used by the EXE stage for DIV/DIVU.
//  - Accepts operands from EXE, runs a restoring shift-subtract loop, returns {remainder, quotient} for HI/LO.
//  - EXE holds its stall request while start_i=1 and ready_o=0.
//  - The result is written to HI/LO through the normal hilo_out path.

---
 rtl/div_seq_pkg.sv | 22 ++
 rtl/div_seq_step.sv | 23 ++
 rtl/div_seq.sv | 162 ++++++++++++++++
 tb/tb_div_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared encodings for the sequential divider: FSM states, handshake levels and EXE op codes.
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_seq_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dvd_bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              quo_bit_o
);

  logic [DATA_W:0]   partial;
  logic [DATA_W+1:0] diff;
  logic              unused_msb;

  assign partial   = {rem_i, dvd_bit_i};
  assign diff      = {1'b0, partial} - {2'b00, divisor_i};
  assign quo_bit_o = ~diff[DATA_W+1];
  // The kept remainder is always below the divisor, so the top bits are known zero.
  assign rem_o      = quo_bit_o ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
  assign unused_msb = ^{diff[DATA_W], partial[DATA_W]};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider sequencer returning {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dq_q, dq_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic              op1_neg, op2_neg, early_out;
  logic [DATA_W-1:0] op1_mag, op2_mag;
  logic [DATA_W-1:0] rem_step, quo_raw, quo_fix, rem_fix;
  logic              q_step;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (op1_mag < op2_mag);
`else
  assign early_out = 1'b0;
`endif

  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dq_q[DATA_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_step),
    .quo_bit_o (q_step)
  );

  assign quo_raw = {dq_q[DATA_W-2:0], q_step};
  assign quo_fix = neg_quo_q ? -quo_raw : quo_raw;
  assign rem_fix = neg_rem_q ? -rem_step : rem_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    if (annul_i) begin
      state_d  = DivFree;
      cnt_d    = '0;
      result_d = '0;
      ready_d  = DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          if (start_i == DivStart) begin
            if (opdata2_i == '0) begin
              state_d = DivByZero;
            end else if (early_out) begin
              state_d  = DivEnd;
              result_d = {opdata1_i, {DATA_W{1'b0}}};
              ready_d  = DivResultReady;
            end else begin
              state_d   = DivOn;
              cnt_d     = '0;
              rem_d     = '0;
              dq_d      = op1_mag;
              dvs_d     = op2_mag;
              neg_quo_d = op1_neg ^ op2_neg;
              neg_rem_d = op1_neg;
            end
          end
        end
        DivByZero: begin
          if (start_i == DivStop) begin
            state_d = DivFree;
          end else begin
            state_d  = DivEnd;
            result_d = '0;
            ready_d  = DivResultReady;
          end
        end
        DivOn: begin
          // Losing start mid-run is handled exactly like an annul.
          if (start_i == DivStop) begin
            state_d = DivFree;
            cnt_d   = '0;
          end else begin
            rem_d = rem_step;
            dq_d  = quo_raw;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W-1)) begin
              state_d  = DivEnd;
              cnt_d    = '0;
              result_d = {rem_fix, quo_fix};
              ready_d  = DivResultReady;
            end
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state_d  = DivFree;
            result_d = '0;
            ready_d  = DivResultNotReady;
          end
        end
        default: state_d = DivFree;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != DivFree);

endmodule

// File: tb/tb_div_seq.sv
// Directed vector bench for div_seq: latency, results, hold/drop handshake, annul and async reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  always #5 clk = ~clk;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[9];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   cyc;
    logic seen;
    signed_div_i = v.sgn;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    start_i      = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check_int({tag, " busy@1"}, int'(busy_o), 1);
      if (ready_o) seen = 1'b1;
    end
    check_int({tag, " latency"}, seen ? cyc : -1, v.lat);
    check64({tag, " result"}, result_o, v.exp);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    repeat (10) @(posedge clk);
    #1;
    check_int({tag, " hold ready"}, int'(ready_o), 1);
    check64({tag, " hold result"}, result_o, v.exp);
    start_i = 1'b0;
    @(posedge clk); #1;
    check_int({tag, " drop ready"}, int'(ready_o), 0);
    check64({tag, " drop result"}, result_o, 64'h0);
    check_int({tag, " drop busy"}, int'(busy_o), 0);
    $display("%s: sgn=%0b %h / %h -> %h after %0d cycles", tag, v.sgn, v.a, v.b, v.exp, cyc);
  endtask

  initial begin
    int   i;
    logic any_ready;
    vecs[0] = '{1'b0, 32'd7,        32'd2,        {32'h1,        32'h3},        33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
    vecs[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0,        32'h80000000}, 33};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'h1,        {32'h0,        32'hFFFFFFFF}, 33};
    vecs[4] = '{1'b1, 32'h12345678, 32'h0,        64'h0,                        2};
    vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'h0,        64'h0,                        2};
    vecs[6] = '{1'b0, 32'd5,        32'd9,        {32'h5,        32'h0},        EO_LAT};
    vecs[7] = '{1'b1, 32'd7,        32'hFFFFFFFE, {32'h1,        32'hFFFFFFFD}, 33};
    vecs[8] = '{1'b1, 32'hFFFFFFFB, 32'd9,        {32'hFFFFFFFB, 32'h0},        EO_LAT};

    #12;
    check_int("reset ready", int'(ready_o), 0);
    check64("reset result", result_o, 64'h0);
    check_int("reset busy", int'(busy_o), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Annul in cycle 10 of RUN; nothing must ever become ready.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk); #1;
    check_int("annul busy@11", int'(busy_o), 0);
    check_int("annul ready@11", int'(ready_o), 0);
    annul_i = 1'b0; start_i = 1'b0;
    any_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) any_ready = 1'b1;
    end
    check_int("annul never ready", int'(any_ready), 0);
    $display("annul: op cancelled at cycle 10");
    run_vec('{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33}, "post-annul");

    // Async reset mid-RUN.
    signed_div_i = 1'b0; opdata1_i = 32'd7; opdata2_i = 32'd2; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_int("rst run busy", int'(busy_o), 0);
    check_int("rst run ready", int'(ready_o), 0);
    start_i = 1'b0;
    #3 rst = 1'b1;
    $display("reset mid-run: block idle");

    // Async reset while holding a valid result in DONE.
    @(posedge clk); #1;
    opdata1_i = 32'd7; opdata2_i = 32'd2; start_i = 1'b1;
    i = 0;
    while (!ready_o && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    check_int("pre-rst ready", int'(ready_o), 1);
    #2 rst = 1'b0;
    #1;
    check_int("rst done ready", int'(ready_o), 0);
    check64("rst done result", result_o, 64'h0);
    check_int("rst done busy", int'(busy_o), 0);
    start_i = 1'b0;
    #3 rst = 1'b1;
    $display("reset in done: outputs cleared");

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
